// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential multiplier/divider pair.
package seq_arith_pkg;

  localparam int DEFAULT_BIT_LEN = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, then
// subtract the divisor when the shifted partial remainder can absorb it.
module seq_div_step
  import seq_arith_pkg::*;
#(
  parameter int BIT_LEN = DEFAULT_BIT_LEN
) (
  input  logic [BIT_LEN-1:0] prem_in,
  input  logic               dvd_msb,
  input  logic [BIT_LEN-1:0] divisor,
  output logic [BIT_LEN-1:0] prem_out,
  output logic               q_bit
);

  logic [BIT_LEN:0] shifted;

  assign shifted = {prem_in, dvd_msb};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // prem_in < divisor keeps the difference within BIT_LEN bits.
  assign prem_out = q_bit ? BIT_LEN'(shifted - {1'b0, divisor}) : shifted[BIT_LEN-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per enabled clock.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating division).
//
// state | meaning
// IDLE  | no division since reset
// RUN   | iterating, one step per enabled cycle
// DONE  | quotient/remainder valid
module seq_divider
  import seq_arith_pkg::*;
#(
  parameter int BIT_LEN = DEFAULT_BIT_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 enable,
  input  logic [2*BIT_LEN-1:0] dividend,
  input  logic [BIT_LEN-1:0]   divisor,
  output logic [2*BIT_LEN-1:0] quotient,
  output logic [BIT_LEN-1:0]   remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero
);

  localparam int DW    = 2 * BIT_LEN;
  localparam int CNT_W = $clog2(DW);

  seq_state_e         state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [BIT_LEN-1:0] prem, prem_nxt;
  logic [DW-1:0]      dvd, dvd_nxt;
  logic [BIT_LEN-1:0] dsr, dsr_nxt;
  logic [DW-1:0]      quot_nxt;
  logic [BIT_LEN-1:0] rem_nxt;
  logic               dbz_nxt;

  logic [BIT_LEN-1:0] step_prem;
  logic               step_q;
  logic [DW-1:0]      q_raw;
  logic [BIT_LEN-1:0] r_raw;
  logic [DW-1:0]      dvd_mag;
  logic [BIT_LEN-1:0] dsr_mag;
  logic [DW-1:0]      q_fin;
  logic [BIT_LEN-1:0] r_fin;

  seq_div_step #(.BIT_LEN(BIT_LEN)) u_step (
    .prem_in (prem),
    .dvd_msb (dvd[DW-1]),
    .divisor (dsr),
    .prem_out(step_prem),
    .q_bit   (step_q)
  );

  // Quotient bits shift into the low end of the dividend register as it drains.
  assign q_raw = {dvd[DW-2:0], step_q};
  assign r_raw = step_prem;

`ifdef SEQ_DIV_SIGNED_EN
  logic dvd_neg_r, dsr_neg_r;

  assign dvd_mag = dividend[DW-1] ? -dividend : dividend;
  assign dsr_mag = divisor[BIT_LEN-1] ? -divisor : divisor;

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_neg_r <= 1'b0;
      dsr_neg_r <= 1'b0;
    end else if (load) begin
      dvd_neg_r <= dividend[DW-1];
      dsr_neg_r <= divisor[BIT_LEN-1];
    end
  end

  // Most-negative / -1 wraps naturally: magnitude and its negation coincide.
  assign q_fin = (dvd_neg_r ^ dsr_neg_r) ? -q_raw : q_raw;
  assign r_fin = dvd_neg_r ? -r_raw : r_raw;
`else
  assign dvd_mag = dividend;
  assign dsr_mag = divisor;
  assign q_fin   = q_raw;
  assign r_fin   = r_raw;
`endif

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    prem_nxt  = prem;
    dvd_nxt   = dvd;
    dsr_nxt   = dsr;
    quot_nxt  = quotient;
    rem_nxt   = remainder;
    dbz_nxt   = div_by_zero;

    if (load) begin
      count_nxt = '0;
      if (divisor == '0) begin
        state_nxt = DONE;
        quot_nxt  = '1;
        rem_nxt   = dividend[BIT_LEN-1:0];
        dbz_nxt   = 1'b1;
      end else begin
        state_nxt = RUN;
        prem_nxt  = '0;
        dvd_nxt   = dvd_mag;
        dsr_nxt   = dsr_mag;
        dbz_nxt   = 1'b0;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (enable) begin
            prem_nxt  = step_prem;
            dvd_nxt   = q_raw;
            count_nxt = count + CNT_W'(1);
            if (count == CNT_W'(DW - 1)) begin
              state_nxt = DONE;
              quot_nxt  = q_fin;
              rem_nxt   = r_fin;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      prem        <= '0;
      dvd         <= '0;
      dsr         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      prem        <= prem_nxt;
      dvd         <= dvd_nxt;
      dsr         <= dsr_nxt;
      quotient    <= quot_nxt;
      remainder   <= rem_nxt;
      div_by_zero <= dbz_nxt;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (BIT_LEN=4) against an arithmetic reference.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic       enable = 1'b1;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy, done, div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider #(.BIT_LEN(4)) dut (
    .clk(clk), .reset(reset), .load(load), .enable(enable),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division on the operands as interpreted numbers.
  function automatic void model(input logic [7:0] a, input logic [3:0] b,
                                output logic [7:0] q, output logic [3:0] r, output logic z);
    int sa, sb;
    if (b == 4'd0) begin
      q = 8'hFF; r = a[3:0]; z = 1'b1;
      return;
    end
`ifdef SEQ_DIV_SIGNED_EN
    sa = int'($signed(a)); sb = int'($signed(b));
`else
    sa = int'(a); sb = int'(b);
`endif
    q = 8'(sa / sb);
    r = 4'(sa % sb);
    z = 1'b0;
  endfunction

  task automatic do_load(input logic [7:0] a, input logic [3:0] b);
    load = 1'b1; dividend = a; divisor = b;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load = (i == 2); dividend = 8'd225; divisor = 4'd15;
      tick();
    end
    load = 1'b0; reset = 1'b0;
    n_tests++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
  endtask

  task automatic test_basic();
    logic [7:0] eq; logic [3:0] er; logic ez;
    model(8'd225, 4'd15, eq, er, ez);
    do_load(8'd225, 4'd15);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_busy[%0d]: got busy=%b done=%b, want busy=1 done=0", i, busy, done);
      end
      tick();
    end
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
      n_fail++;
      $display("FAIL basic_225_15: got done=%b busy=%b q=%h r=%h dbz=%b, want done=1 busy=0 q=%h r=%h dbz=%b",
               done, busy, quotient, remainder, div_by_zero, eq, er, ez);
    end
  endtask

  task automatic test_div_zero();
    do_load(8'h23, 4'd0);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || div_by_zero !== 1'b1 || quotient !== 8'hFF || remainder !== 4'h3) begin
      n_fail++;
      $display("FAIL div_zero: got done=%b busy=%b dbz=%b q=%h r=%h, want done=1 busy=0 dbz=1 q=ff r=3",
               done, busy, div_by_zero, quotient, remainder);
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || quotient !== 8'hFF) begin
      n_fail++;
      $display("FAIL div_zero_hold: got done=%b q=%h, want done=1 q=ff", done, quotient);
    end
  endtask

  task automatic test_stall();
    logic [7:0] eq; logic [3:0] er; logic ez;
    int cyc;
    model(8'd7, 4'd2, eq, er, ez);
    do_load(8'd7, 4'd2);
    n_tests++;
    if (quotient !== 8'hFF || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_during_run: got q=%h dbz=%b, want q=ff dbz=0", quotient, div_by_zero);
    end
    repeat (8) tick();
    n_tests++;
    if (done !== 1'b1 || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
      n_fail++;
      $display("FAIL div_7_2: got done=%b q=%h r=%h dbz=%b, want done=1 q=%h r=%h dbz=%b",
               done, quotient, remainder, div_by_zero, eq, er, ez);
    end
    model(8'd100, 4'd7, eq, er, ez);
    do_load(8'd100, 4'd7);
    cyc = 0;
    while (done !== 1'b1 && cyc < 30) begin
      enable = !(cyc >= 3 && cyc < 6);
      tick();
      cyc++;
      if (cyc >= 3 && cyc < 6) begin
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_busy[%0d]: got busy=%b, want 1", cyc, busy);
        end
      end
    end
    enable = 1'b1;
    n_tests++;
    if (cyc !== 11 || quotient !== eq || remainder !== er) begin
      n_fail++;
      $display("FAIL stall_100_7: got edges=%0d q=%h r=%h, want edges=11 q=%h r=%h",
               cyc, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_reload();
    logic [7:0] eq; logic [3:0] er; logic ez;
    model(8'd50, 4'd5, eq, er, ez);
    do_load(8'd200, 4'd9);
    repeat (4) tick();
    do_load(8'd50, 4'd5);
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL reload_early_done[%0d]: got done=%b, want 0", i, done);
      end
      tick();
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || quotient !== eq || remainder !== er) begin
      n_fail++;
      $display("FAIL reload_50_5: got done=%b q=%h r=%h, want done=1 q=%h r=%h",
               done, quotient, remainder, eq, er);
    end
    do_load(8'd200, 4'd9);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    repeat (10) tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, eq; logic [3:0] b, er; logic ez;
    int steps, cyc;
    logic en;
    for (int t = 0; t < 40; t++) begin
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(0, 15));
      model(a, b, eq, er, ez);
      do_load(a, b);
      steps = 0; cyc = 0;
      if (b != 4'd0) begin
        while (steps < 8 && cyc < 60) begin
          n_tests++;
          if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_run[%0d]: %0d/%0d step %0d got busy=%b done=%b, want 1 0",
                     t, a, b, steps, busy, done);
          end
          en = ($urandom_range(0, 3) != 0);
          enable = en;
          tick();
          if (en) steps++;
          cyc++;
        end
        enable = 1'b1;
      end
      n_tests++;
      if (done !== 1'b1 || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
        n_fail++;
        $display("FAIL rand_result[%0d]: %h/%h got done=%b q=%h r=%h dbz=%b, want done=1 q=%h r=%h dbz=%b",
                 t, a, b, done, quotient, remainder, div_by_zero, eq, er, ez);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

`ifdef SEQ_DIV_SIGNED_EN
  task automatic test_signed();
    do_load(8'hF9, 4'd2);
    repeat (8) tick();
    n_tests++;
    if (done !== 1'b1 || quotient !== 8'hFD || remainder !== 4'hF) begin
      n_fail++;
      $display("FAIL signed_m7_2: got done=%b q=%h r=%h, want done=1 q=fd r=f", done, quotient, remainder);
    end
    do_load(8'h80, 4'hF);
    repeat (8) tick();
    n_tests++;
    if (done !== 1'b1 || quotient !== 8'h80 || remainder !== 4'h0) begin
      n_fail++;
      $display("FAIL signed_wrap: got done=%b q=%h r=%h, want done=1 q=80 r=0", done, quotient, remainder);
    end
  endtask
`endif

  initial begin
    tick();
    test_reset();
    test_basic();
    test_div_zero();
    test_stall();
    test_reload();
    test_random();
`ifdef SEQ_DIV_SIGNED_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
